major_cycle_sequencer: RTL and testbench

- Timing and phase controller for the CPU core.
- Generates the one-hot step clocks (ck) and strobes (stb) that drive the memory-reference instruction decoder.
- Sequences the FETCH, AUTOINC (auto-index pointer update), EXEC and IRQ major phases, and handles run/stop/single-step control.
- Ends EXEC when the decoder raises done.

---
 rtl/major_cycle_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_major_cycle_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/major_cycle_sequencer.sv
// Major-phase/step sequencer (HALT/FETCH/AUTOINC/EXEC/IRQ); 2 clocks per step, no gap cycles; stop/sstep honoured at boundaries.
// Optional SEQ_WATCHDOG_EN: an EXEC overrun sets sticky seqErr and halts, instead of holding ck/stb at the last step.
module major_cycle_sequencer #(
  parameter int NSTEPS      = 6,
  parameter int FETCH_STEPS = 2,
  parameter int AUTO_STEPS  = 3,
  parameter int IRQ_STEPS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              sstep,
  input  logic              stop,
  input  logic              done,
  input  logic              instIsPPIND,
  input  logic              irqReq,
  input  logic              irqEnable,
  output logic [NSTEPS-1:0] ck,
  output logic [NSTEPS-1:0] stb,
  output logic              phFetch,
  output logic              phAuto,
  output logic              phExec,
  output logic              phIrq,
  output logic              irqOverride,
  output logic              running,
  output logic              seqErr
);

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_AUTO,
    S_EXEC,
    S_IRQ
  } state_t;

  localparam logic [NSTEPS-1:0] STEP1 = NSTEPS'(1);

  state_t            state_q, state_d;
  logic [NSTEPS-1:0] ck_d;
  logic              sub_b_q, sub_b_d;
  logic              hold_q, hold_d;
  logic              stop_pend_q, stop_pend_d;
  logic              sstep_pend_q, sstep_pend_d;
  logic              last_step;
  logic              boundary;
  logic              irq_ok;
  logic              go_halt;
`ifdef SEQ_WATCHDOG_EN
  logic              seq_err_q, seq_err_d;
`endif

  always_comb begin
    last_step = 1'b0;
    case (state_q)
      S_FETCH: last_step = ck[FETCH_STEPS-1];
      S_AUTO:  last_step = ck[AUTO_STEPS-1];
      S_EXEC:  last_step = ck[NSTEPS-1];
      S_IRQ:   last_step = ck[IRQ_STEPS-1];
      default: last_step = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ck_d         = ck;
    sub_b_d      = sub_b_q;
    hold_d       = hold_q;
    stop_pend_d  = stop_pend_q | (stop && (state_q != S_HALT));
    sstep_pend_d = sstep_pend_q;
    boundary     = 1'b0;
    irq_ok       = 1'b0;
    go_halt      = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    seq_err_d    = seq_err_q;
`endif

    case (state_q)
      S_HALT: begin
        if (!stop && (run || sstep)) begin
          state_d      = S_FETCH;
          ck_d         = STEP1;
          sub_b_d      = 1'b0;
          sstep_pend_d = !run;
        end
      end
      S_EXEC: begin
        // done only counts in sub-cycle A, or while parked on the final step
        if (!sub_b_q) begin
          if (done) begin
            boundary = 1'b1;
            irq_ok   = 1'b1;
          end else begin
            sub_b_d = 1'b1;
          end
        end else if (hold_q) begin
          if (done) begin
            boundary = 1'b1;
            irq_ok   = 1'b1;
          end
        end else if (last_step) begin
`ifdef SEQ_WATCHDOG_EN
          seq_err_d = 1'b1;
          go_halt   = 1'b1;
`else
          hold_d    = 1'b1;
`endif
        end else begin
          ck_d    = ck << 1;
          sub_b_d = 1'b0;
        end
      end
      default: begin
        if (!sub_b_q) begin
          sub_b_d = 1'b1;
        end else if (!last_step) begin
          ck_d    = ck << 1;
          sub_b_d = 1'b0;
        end else begin
          ck_d    = STEP1;
          sub_b_d = 1'b0;
          case (state_q)
            S_FETCH: state_d  = instIsPPIND ? S_AUTO : S_EXEC;
            S_AUTO:  state_d  = S_EXEC;
            default: boundary = 1'b1;
          endcase
        end
      end
    endcase

    if (boundary) begin
      ck_d    = STEP1;
      sub_b_d = 1'b0;
      hold_d  = 1'b0;
      if (stop_pend_d || sstep_pend_q) begin
        go_halt = 1'b1;
      end else if (irq_ok && irqReq && irqEnable) begin
        state_d = S_IRQ;
      end else begin
        state_d = S_FETCH;
      end
    end

    if (go_halt) begin
      state_d      = S_HALT;
      ck_d         = '0;
      sub_b_d      = 1'b0;
      hold_d       = 1'b0;
      stop_pend_d  = 1'b0;
      sstep_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HALT;
      ck           <= '0;
      stb          <= '0;
      sub_b_q      <= 1'b0;
      hold_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      sstep_pend_q <= 1'b0;
      phFetch      <= 1'b0;
      phAuto       <= 1'b0;
      phExec       <= 1'b0;
      phIrq        <= 1'b0;
      irqOverride  <= 1'b0;
      running      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ck           <= ck_d;
      stb          <= sub_b_d ? ck_d : '0;
      sub_b_q      <= sub_b_d;
      hold_q       <= hold_d;
      stop_pend_q  <= stop_pend_d;
      sstep_pend_q <= sstep_pend_d;
      phFetch      <= (state_d == S_FETCH);
      phAuto       <= (state_d == S_AUTO);
      phExec       <= (state_d == S_EXEC);
      phIrq        <= (state_d == S_IRQ);
      irqOverride  <= (state_d == S_IRQ);
      running      <= (state_d != S_HALT);
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) seq_err_q <= 1'b0;
    else       seq_err_q <= seq_err_d;
  end
  assign seqErr = seq_err_q;
`else
  assign seqErr = 1'b0;
`endif

endmodule

// File: tb/tb_major_cycle_sequencer.sv
// Directed bench for major_cycle_sequencer: phase/step trace checked every clock.
module tb_major_cycle_sequencer;
  localparam int NS = 6;
  localparam int H = 0, F = 1, A = 2, E = 3, I = 4;

  logic clk = 1'b0;
  logic reset, run, sstep, stop, done, ppind, irq_req, irq_en;
  logic [NS-1:0] ck, stb;
  logic ph_f, ph_a, ph_e, ph_i, irq_ovr, running, seq_err;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  major_cycle_sequencer #(.NSTEPS(NS), .FETCH_STEPS(2), .AUTO_STEPS(3), .IRQ_STEPS(2)) dut (
    .clk(clk), .reset(reset), .run(run), .sstep(sstep), .stop(stop), .done(done),
    .instIsPPIND(ppind), .irqReq(irq_req), .irqEnable(irq_en),
    .ck(ck), .stb(stb), .phFetch(ph_f), .phAuto(ph_a), .phExec(ph_e), .phIrq(ph_i),
    .irqOverride(irq_ovr), .running(running), .seqErr(seq_err)
  );

  function automatic logic [18:0] exp_word(int ph, int step, bit b, bit err);
    logic [NS-1:0] c;
    logic [NS-1:0] s;
    c = (step == 0) ? '0 : (NS'(1) << (step - 1));
    s = b ? c : '0;
    return {ph != 0, ph == F, ph == A, ph == E, ph == I, ph == I, err, c, s};
  endfunction

  task automatic chk(string tag, int ph, int step, bit b, bit err = 1'b0);
    logic [18:0] obs, expv;
    obs  = {running, ph_f, ph_a, ph_e, ph_i, irq_ovr, seq_err, ck, stb};
    expv = exp_word(ph, step, b, err);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s ph=%0d step=%0d b=%0d observed=%h expected=%h", tag, ph, step, b, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(string tag, int ph, int step, bit b, bit err = 1'b0);
    tick();
    chk(tag, ph, step, b, err);
  endtask

  // Walks n steps of a phase; skip_a when the first A cycle was already checked.
  task automatic walk(string tag, int ph, int n, bit skip_a);
    for (int s = 1; s <= n; s++) begin
      if (!(s == 1 && skip_a)) cyc(tag, ph, s, 1'b0);
      cyc(tag, ph, s, 1'b1);
    end
  endtask

  // From a checked F1A: rest of FETCH, presenting p as the indirect flag.
  task automatic fetch_rest(string tag, bit p);
    walk(tag, F, 2, 1'b1);
    ppind = p;
  endtask

  // EXEC from step 1 A up to step d A, where the decoder raises done.
  task automatic exec_done(string tag, int d);
    walk(tag, E, d - 1, 1'b0);
    cyc(tag, E, d, 1'b0);
    done = 1'b1;
  endtask

  task automatic end_instr(string tag, int ph);
    tick();
    done = 1'b0;
    chk(tag, ph, (ph == H) ? 0 : 1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; sstep = 1'b0; stop = 1'b0; done = 1'b0;
    ppind = 1'b0; irq_req = 1'b0; irq_en = 1'b0;
    tick();
    tick();
    chk("reset", H, 0, 1'b0);
    reset = 1'b0;
    cyc("idle", H, 0, 1'b0);

    // TAD-like: 4 FETCH + 3 EXEC clocks, back-to-back into the next FETCH
    run = 1'b1;
    cyc("tad_start", F, 1, 1'b0);
    run = 1'b0;
    fetch_rest("tad_fetch", 1'b0);
    exec_done("tad_exec", 2);
    end_instr("tad_next", F);

    // ISZ-like through AUTOINC, with stop raised at F1A: completes, then halts
    stop = 1'b1;
    fetch_rest("isz_fetch", 1'b1);
    stop = 1'b0;
    walk("isz_auto", A, 3, 1'b0);
    ppind = 1'b0;
    exec_done("isz_exec", 5);
    end_instr("isz_halt", H);

    // stop beats run in HALT
    stop = 1'b1; run = 1'b1;
    cyc("stop_run_halt", H, 0, 1'b0);
    stop = 1'b0; run = 1'b0;
    cyc("stop_run_halt2", H, 0, 1'b0);

    // single step twice
    sstep = 1'b1;
    cyc("ss1_start", F, 1, 1'b0);
    sstep = 1'b0;
    fetch_rest("ss1_fetch", 1'b0);
    exec_done("ss1_exec", 2);
    end_instr("ss1_halt", H);
    cyc("ss1_stay", H, 0, 1'b0);
    sstep = 1'b1;
    cyc("ss2_start", F, 1, 1'b0);
    sstep = 1'b0;
    fetch_rest("ss2_fetch", 1'b0);
    exec_done("ss2_exec", 2);
    end_instr("ss2_halt", H);
    cyc("ss2_stay", H, 0, 1'b0);

    // DCA-like with interrupt pending: IRQ for 4 clocks, then FETCH
    run = 1'b1;
    cyc("dca_start", F, 1, 1'b0);
    fetch_rest("dca_fetch", 1'b0);
    irq_req = 1'b1; irq_en = 1'b1;
    exec_done("dca_exec", 3);
    end_instr("irq_enter", I);
    irq_req = 1'b0;
    cyc("irq_1b", I, 1, 1'b1);
    cyc("irq_2a", I, 2, 1'b0);
    cyc("irq_2b", I, 2, 1'b1);
    cyc("irq_exit", F, 1, 1'b0);

    // interrupt disabled: no IRQ entry
    irq_req = 1'b1; irq_en = 1'b0;
    fetch_rest("dca2_fetch", 1'b0);
    exec_done("dca2_exec", 3);
    end_instr("noirq_next", F);
    irq_req = 1'b0;

    // EXEC overrun: done never raised through step 6
    fetch_rest("ovr_fetch", 1'b0);
    walk("ovr_exec", E, NS, 1'b0);
`ifdef SEQ_WATCHDOG_EN
    cyc("wd_halt", H, 0, 1'b0, 1'b1);
    cyc("wd_restart", F, 1, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("wd_reset", H, 0, 1'b0);
    cyc("wd_rerun", F, 1, 1'b0);
`else
    cyc("hold1", E, NS, 1'b1);
    cyc("hold2", E, NS, 1'b1);
    cyc("hold3", E, NS, 1'b1);
    done = 1'b1;
    end_instr("hold_done", F);
`endif

    // reset mid-EXEC clears everything on the next clock
    fetch_rest("rst_fetch", 1'b0);
    cyc("rst_e1a", E, 1, 1'b0);
    cyc("rst_e1b", E, 1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run = 1'b0;
    chk("rst_mid_exec", H, 0, 1'b0);
    cyc("rst_after", H, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
